// File: rtl/pipe_muldiv_seq_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer:
// funct3 codes, FSM state encoding and operand-signedness helpers.
package pipe_muldiv_seq_pkg;

  localparam logic [2:0] FUNCT3_MULDIV_MUL    = 3'd0;
  localparam logic [2:0] FUNCT3_MULDIV_MULH   = 3'd1;
  localparam logic [2:0] FUNCT3_MULDIV_MULHSU = 3'd2;
  localparam logic [2:0] FUNCT3_MULDIV_MULHU  = 3'd3;
  localparam logic [2:0] FUNCT3_MULDIV_DIV    = 3'd4;
  localparam logic [2:0] FUNCT3_MULDIV_DIVU   = 3'd5;
  localparam logic [2:0] FUNCT3_MULDIV_REM    = 3'd6;
  localparam logic [2:0] FUNCT3_MULDIV_REMU   = 3'd7;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } mdState_t;

  function automatic logic aIsSigned(input logic [2:0] funct3);
    return funct3 inside {FUNCT3_MULDIV_MULH, FUNCT3_MULDIV_MULHSU,
                          FUNCT3_MULDIV_DIV, FUNCT3_MULDIV_REM};
  endfunction

  function automatic logic bIsSigned(input logic [2:0] funct3);
    return funct3 inside {FUNCT3_MULDIV_MULH, FUNCT3_MULDIV_DIV, FUNCT3_MULDIV_REM};
  endfunction

endpackage

// File: rtl/riscv_muldiv_iter.sv
// Combinational single step of the iterative datapath: one shift-add multiply
// step or one restoring-divide step on unsigned magnitudes.
module riscv_muldiv_iter #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] sh,
  input  logic [XLEN-1:0] opnd,
  input  logic            isDiv,
  output logic [XLEN-1:0] accNext,
  output logic [XLEN-1:0] shNext
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // Multiply: {acc,sh} is the product register, sh[0] is the current multiplier bit.
  assign sum = {1'b0, acc} + ({(XLEN+1){sh[0]}} & {1'b0, opnd});
  // Divide: acc is the partial remainder, sh shifts the dividend out and quotient in.
  assign shifted = {acc, sh[XLEN-1]};
  assign diff    = shifted - {1'b0, opnd};

  always_comb begin
    accNext = '0;
    shNext  = '0;
    if (isDiv) begin
      if (!diff[XLEN]) begin
        accNext = diff[XLEN-1:0];
        shNext  = {sh[XLEN-2:0], 1'b1};
      end else begin
        accNext = shifted[XLEN-1:0];
        shNext  = {sh[XLEN-2:0], 1'b0};
      end
    end else begin
      accNext = sum[XLEN:1];
      shNext  = {sum[0], sh[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/pipe_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer beside the Execute-stage ALU.
// state   | meaning
// MD_IDLE | waiting for an M op from Execute
// MD_CALC | one datapath step per cycle, count 0..XLEN-1
// MD_DONE | result valid, pipeline released for one cycle
module pipe_muldiv_seq
  import pipe_muldiv_seq_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_md_start,
  input  logic [2:0]      i_md_funct3,
  input  logic [XLEN-1:0] i_md_a,
  input  logic [XLEN-1:0] i_md_b,
  input  logic            i_md_flush,
  output logic [XLEN-1:0] o_md_result,
  output logic            o_md_done,
  output logic            o_md_busy,
  output logic            o_md_stall
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_COUNT = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_INT    = {1'b1, {(XLEN-1){1'b0}}};

  mdState_t state, stateNext;
  logic [CW-1:0]   count;
  logic [2:0]      f3Q;
  logic [XLEN-1:0] accQ, shQ, opndQ;
  logic [XLEN-1:0] accNext, shNext;
  logic            negResQ, negRemQ;

  logic            accept, isDiv, signA, signB, divZero, overflow, special;
  logic [XLEN-1:0] magA, magB, specialResult, finalResult, quotFix, remFix;
  logic [2*XLEN-1:0] product, productFix;

  assign accept   = (state == MD_IDLE) & i_md_start & ~i_md_flush;
  assign isDiv    = i_md_funct3[2];
  assign signA    = aIsSigned(i_md_funct3) & i_md_a[XLEN-1];
  assign signB    = bIsSigned(i_md_funct3) & i_md_b[XLEN-1];
  assign magA     = signA ? -i_md_a : i_md_a;
  assign magB     = signB ? -i_md_b : i_md_b;
  assign divZero  = (i_md_b == '0);
  assign overflow = isDiv & bIsSigned(i_md_funct3) & (i_md_a == MIN_INT) & (i_md_b == '1);
  assign special  = isDiv & (divZero | overflow);

  always_comb begin
    specialResult = '0;
    if (divZero)
      specialResult = i_md_funct3[1] ? i_md_a : '1;
    else
      specialResult = i_md_funct3[1] ? '0 : MIN_INT;
  end

  riscv_muldiv_iter #(.XLEN(XLEN)) uIter (
    .acc     (accQ),
    .sh      (shQ),
    .opnd    (opndQ),
    .isDiv   (f3Q[2]),
    .accNext (accNext),
    .shNext  (shNext)
  );

  // Sign fix is taken from the final step's outputs so the result registers on the last CALC edge.
  assign product    = {accNext, shNext};
  assign productFix = negResQ ? -product : product;
  assign quotFix    = negResQ ? -shNext : shNext;
  assign remFix     = negRemQ ? -accNext : accNext;

  always_comb begin
    finalResult = remFix;
    case (f3Q)
      FUNCT3_MULDIV_MUL:                                          finalResult = productFix[XLEN-1:0];
      FUNCT3_MULDIV_MULH, FUNCT3_MULDIV_MULHSU, FUNCT3_MULDIV_MULHU: finalResult = productFix[2*XLEN-1:XLEN];
      FUNCT3_MULDIV_DIV, FUNCT3_MULDIV_DIVU:                      finalResult = quotFix;
      default:                                                    finalResult = remFix;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      MD_IDLE: if (accept) stateNext = (FAST_SPECIAL && special) ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (i_md_flush)               stateNext = MD_IDLE;
        else if (count == LAST_COUNT) stateNext = MD_DONE;
      end
      MD_DONE: stateNext = MD_IDLE;
      default: stateNext = MD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= MD_IDLE;
      count       <= '0;
      f3Q         <= '0;
      accQ        <= '0;
      shQ         <= '0;
      opndQ       <= '0;
      negResQ     <= 1'b0;
      negRemQ     <= 1'b0;
      o_md_result <= '0;
    end else begin
      state <= stateNext;
      case (state)
        MD_IDLE: begin
          if (accept) begin
            f3Q     <= i_md_funct3;
            count   <= '0;
            accQ    <= '0;
            shQ     <= isDiv ? magA : magB;
            opndQ   <= isDiv ? magB : magA;
            negResQ <= (signA ^ signB) & ~(isDiv & divZero);
            negRemQ <= signA;
            if (FAST_SPECIAL && special) o_md_result <= specialResult;
          end
        end
        MD_CALC: begin
          if (!i_md_flush) begin
            accQ  <= accNext;
            shQ   <= shNext;
            count <= count + 1'b1;
            if (count == LAST_COUNT) o_md_result <= finalResult;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_md_busy  = (state != MD_IDLE);
  assign o_md_done  = (state == MD_DONE) & ~i_md_flush;
  assign o_md_stall = (accept & ~i_rst) | (state == MD_CALC);

endmodule

// File: tb/tb_pipe_muldiv_seq.sv
// Self-checking bench: fast-special and iterate-always sequencers side by side,
// compared against a 64-bit arithmetic reference of the RV32M rules.
module tb_pipe_muldiv_seq;

  logic        clk, rst, start, flush;
  logic [2:0]  f3;
  logic [31:0] opA, opB;
  logic [31:0] resF, resS;
  logic        doneF, doneS, busyF, busyS, stallF, stallS;

  int checks = 0;
  int errors = 0;
  logic [31:0] lastExp;

  pipe_muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b1)) dutFast (
    .i_clk(clk), .i_rst(rst), .i_md_start(start), .i_md_funct3(f3),
    .i_md_a(opA), .i_md_b(opB), .i_md_flush(flush),
    .o_md_result(resF), .o_md_done(doneF), .o_md_busy(busyF), .o_md_stall(stallF));

  pipe_muldiv_seq #(.XLEN(32), .FAST_SPECIAL(1'b0)) dutSlow (
    .i_clk(clk), .i_rst(rst), .i_md_start(start), .i_md_funct3(f3),
    .i_md_a(opA), .i_md_b(opB), .i_md_flush(flush),
    .o_md_result(resS), .o_md_done(doneS), .o_md_busy(busyS), .o_md_stall(stallS));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] refModel(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ub, r;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    up = {32'b0, a} * {32'b0, b};
    r  = 0;
    case (fn)
      3'd0: r = sa * sb;
      3'd1: r = (sa * sb) >>> 32;
      3'd2: r = (sa * ub) >>> 32;
      3'd3: r = longint'(up >> 32);
      3'd4: r = (b == 0) ? -1 : sa / sb;
      3'd5: r = (b == 0) ? -1 : longint'({32'b0, a / b});
      3'd6: r = (b == 0) ? sa : sa % sb;
      default: r = (b == 0) ? sa : longint'({32'b0, a % b});
    endcase
    return r[31:0];
  endfunction

  task automatic runOp(input string tag, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp, gotF, gotS;
    logic        special;
    int expLatF, doneAtF, doneAtS, nDoneF, nDoneS, nStallF, nStallS;
    exp     = refModel(fn, a, b);
    special = fn[2] && (b == 0 || (!fn[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    expLatF = special ? 1 : 33;
    doneAtF = -1; doneAtS = -1; nDoneF = 0; nDoneS = 0;
    gotF = 'x; gotS = 'x;
    @(negedge clk);
    start = 1'b1; f3 = fn; opA = a; opB = b;
    #1;
    nStallF = int'(stallF);
    nStallS = int'(stallS);
    @(posedge clk);
    #1;
    start = 1'b0; opA = $urandom; opB = $urandom; f3 = 3'($urandom_range(0, 7));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      nStallF += int'(stallF);
      nStallS += int'(stallS);
      if (doneF) begin nDoneF++; doneAtF = c; gotF = resF; end
      if (doneS) begin nDoneS++; doneAtS = c; gotS = resS; end
    end
    chk({tag, ".latFast"}, 32'(doneAtF), 32'(expLatF));
    chk({tag, ".latSlow"}, 32'(doneAtS), 32'd33);
    chk({tag, ".resFast"}, gotF, exp);
    chk({tag, ".resSlow"}, gotS, exp);
    chk({tag, ".pulsesFast"}, 32'(nDoneF), 32'd1);
    chk({tag, ".pulsesSlow"}, 32'(nDoneS), 32'd1);
    chk({tag, ".stallFast"}, 32'(nStallF), 32'(expLatF));
    chk({tag, ".stallSlow"}, 32'(nStallS), 32'd33);
    chk({tag, ".holdFast"}, resF, exp);
    chk({tag, ".holdSlow"}, resS, exp);
    lastExp = exp;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; f3 = 3'd0; opA = '0; opB = '0;
    lastExp = '0;
    #12;
    chk("rst.result", resF, 32'h0);
    chk("rst.done", {31'b0, doneF}, 32'h0);
    chk("rst.busy", {31'b0, busyF}, 32'h0);
    start = 1'b1;
    #1;
    chk("rst.stallIgnoresStart", {31'b0, stallF | stallS}, 32'h0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    runOp("mulNeg",  3'd0, 32'd7,          32'hFFFF_FFFD);
    chk("mulNeg.value", lastExp, 32'hFFFF_FFEB);
    runOp("mulhMin", 3'd1, 32'h8000_0000, 32'h8000_0000);
    chk("mulhMin.value", lastExp, 32'h4000_0000);
    runOp("mulhu",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("mulhsu",  3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    runOp("divNeg",  3'd4, 32'hFFFF_FFF9, 32'd2);
    runOp("remNeg",  3'd6, 32'hFFFF_FFF9, 32'd2);
    runOp("divu",    3'd5, 32'd100,       32'd7);
    runOp("remu",    3'd7, 32'd100,       32'd7);
    runOp("divuZero",3'd5, 32'd100,       32'd0);
    runOp("remuZero",3'd7, 32'd100,       32'd0);
    runOp("divZero", 3'd4, 32'hFFFF_FFF9, 32'd0);
    runOp("divOvf",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("remOvf",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    runOp("divuBig", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF);

    // start blocked by flush while idle
    @(negedge clk);
    start = 1'b1; flush = 1'b1; f3 = 3'd0; opA = 32'd3; opB = 32'd3;
    #1;
    chk("idleFlush.stall", {31'b0, stallF}, 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("idleFlush.busy", {31'b0, busyF | busyS}, 32'h0);

    // flush mid-divide at count 10
    @(negedge clk);
    start = 1'b1; f3 = 3'd4; opA = 32'd1000; opB = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush.noDoneInCalc", {31'b0, doneF | doneS}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush.busyDrop", {31'b0, busyF | busyS}, 32'h0);
    chk("flush.stallDrop", {31'b0, stallF | stallS}, 32'h0);
    begin
      int seen = 0;
      for (int c = 0; c < 36; c++) begin
        @(negedge clk);
        seen += int'(doneF) + int'(doneS);
      end
      chk("flush.noDonePulse", 32'(seen), 32'd0);
    end
    chk("flush.resultKeptFast", resF, lastExp);
    chk("flush.resultKeptSlow", resS, lastExp);
    runOp("mulAfterFlush", 3'd0, 32'd3, 32'd5);

    // asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; f3 = 3'd0; opA = 32'd9; opB = 32'd9;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("asyncRst.busyBefore", {31'b0, busyF}, 32'h1);
    rst = 1'b1;
    #1;
    chk("asyncRst.busy", {31'b0, busyF | busyS}, 32'h0);
    chk("asyncRst.stall", {31'b0, stallF | stallS}, 32'h0);
    chk("asyncRst.done", {31'b0, doneF | doneS}, 32'h0);
    chk("asyncRst.result", resF | resS, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    runOp("mulAfterRst", 3'd0, 32'd2, 32'd2);

    for (int i = 0; i < 20; i++) begin
      logic [2:0]  rf;
      logic [31:0] ra, rb;
      int sel;
      rf  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) rb = 32'd0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) rb = 32'($urandom_range(1, 15));
      runOp($sformatf("rand%0d_f%0d", i, rf), rf, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
